serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 1..64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request: capture operands and begin an addition.
REQ-005 a  input  WIDTH  operand A, unsigned, sampled only on an accepted start.
REQ-006 b  input  WIDTH  operand B, unsigned, sampled only on an accepted start.
REQ-007 cin  input  1  carry-in, sampled only on an accepted start.
REQ-008 busy  output  1  high while a bit-serial addition is in progress.
REQ-009 done  output  1  one-cycle pulse: sum/cout have just been updated.
REQ-010 sum  output  WIDTH  result register, low WIDTH bits of a+b+cin.
REQ-011 cout  output  1  result carry-out, bit WIDTH of a+b+cin.

Function
REQ-012 FSM states: IDLE, RUN, FIN; all outputs registered.
REQ-013 Start is accepted only in IDLE or FIN when start=1 at a rising edge. Operands and cin are loaded into internal shift/carry registers, the bit counter is cleared to 0, and the state becomes RUN.
REQ-014 Start is ignored in RUN. Operand inputs are don't-care except on the accepting edge.
REQ-015 In RUN, each edge adds the current LSBs of the A/B shift registers plus the carry register with one full adder. The result bit shifts into the MSB of a partial-result register, the carry register is updated, the operand registers shift right by 1, and the counter increments.
REQ-016 When the counter reaches WIDTH-1 in RUN, the next edge does four things: completes the final bit, copies the partial result to sum and the final carry to cout, and moves the state to FIN.
REQ-017 Latency: with start accepted at edge 0, busy=1 in cycles 1..WIDTH, and done=1 in cycle WIDTH+1 only.
REQ-018 In FIN without start, the state returns to IDLE on the next edge. With start in FIN, the state goes directly to RUN (back-to-back, no idle cycle).
REQ-019 sum and cout hold their previous result throughout RUN and change only on the RUN->FIN edge. They hold until the next completion or reset.
REQ-020 busy=1 exactly when state=RUN; done=1 exactly when state=FIN.
REQ-021 WIDTH=1: exactly one RUN cycle; the result equals a full-adder truth table.
REQ-022 The counter is $clog2(WIDTH+1) bits wide and never wraps within an operation.

Reset
REQ-023 When rst=1 at an edge, the state becomes IDLE; busy=0, done=0, sum=0, cout=0; and the counter, carry, and shift registers are cleared. This takes priority over start and over any in-flight operation.
REQ-024 An operation aborted by reset produces no done pulse and leaves sum/cout at 0.

Structure
REQ-025 Shared package serial_adder_pkg holds the state enum typedef (IDLE, RUN, FIN) and the default WIDTH constant.
REQ-026 One sub-module, full_adder (combinational: a, b, cin -> sum, cout), is instantiated once for the bit-slice.

Verification
REQ-027 WIDTH=8, a=0x00, b=0x00, cin=0, start pulse -> busy cycles 1..8, done in cycle 9, sum=0x00, cout=0.
REQ-028 WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-029 WIDTH=8, a=0x3C, b=0x5A accepted, then start held with a=0x11 during RUN -> result is sum=0x96, cout=0 with one done pulse. While start is still high in the FIN cycle, the second operation (a=0x11, b=0x5A) starts back-to-back and ends with sum=0x6B.
REQ-030 WIDTH=8, rst asserted in cycle 4 of RUN -> next cycle busy=0, done=0, sum=0, cout=0; no done pulse follows.
REQ-031 WIDTH=1, all four (a,b) combinations with cin=0 -> (sum,cout) = (0,0),(1,0),(1,0),(0,1), each with done in cycle 2.
REQ-032 WIDTH=16 random self-check, 1000 operations -> {cout,sum} equals a+b+cin, and latency equals WIDTH+1 every time.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
// Holds the FSM state encoding and the default operand width.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder used as the serial bit-slice.
// Purely combinational.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one bit per clock, LSB first.
// Result appears in sum/cout with a one-cycle done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] part;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             fa_s;
    logic             fa_c;
    logic [WIDTH:0]   part_cat;
    logic [WIDTH-1:0] part_nxt;

    full_adder u_fa (
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .cin  (carry),
        .sum  (fa_s),
        .cout (fa_c)
    );

    // Concatenate then drop the LSB so WIDTH=1 needs no special case.
    always_comb begin
        part_cat = {fa_s, part};
        part_nxt = part_cat[WIDTH:1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            sh_a  <= '0;
            sh_b  <= '0;
            part  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            unique case (state)
                IDLE, FIN: begin
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        carry <= cin;
                        part  <= '0;
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    done <= 1'b0;
                end
                RUN: begin
                    part  <= part_nxt;
                    carry <= fa_c;
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= part_nxt;
                        cout  <= fa_c;
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized checks of serial_adder at WIDTH 8, 1 and 16.
// Expected values are hand-computed or taken from a+b+cin.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic       s8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       c8 = 1'b0;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    logic       s1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       c1 = 1'b0;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    logic        s16 = 1'b0;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic        c16 = 1'b0;
    logic        busy16;
    logic        done16;
    logic [15:0] sum16;
    logic        cout16;

    serial_adder #(.WIDTH(8)) u8 (
        .clk   (clk),
        .rst   (rst),
        .start (s8),
        .a     (a8),
        .b     (b8),
        .cin   (c8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(1)) u1 (
        .clk   (clk),
        .rst   (rst),
        .start (s1),
        .a     (a1),
        .b     (b1),
        .cin   (c1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    serial_adder #(.WIDTH(16)) u16 (
        .clk   (clk),
        .rst   (rst),
        .start (s16),
        .a     (a16),
        .b     (b16),
        .cin   (c16),
        .busy  (busy16),
        .done  (done16),
        .sum   (sum16),
        .cout  (cout16)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Starts one 8-bit op from IDLE and checks every cycle up to done+1.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb,
                       input logic tc, input logic [7:0] es,
                       input logic ec, input logic [7:0] prev);
        @(negedge clk);
        s8 = 1'b1; a8 = ta; b8 = tb; c8 = tc;
        @(negedge clk);
        s8 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            check("busy8_run", busy8, 1);
            check("done8_run", done8, 0);
            check("sum8_hold", sum8, prev);
            @(negedge clk);
        end
        check("done8", done8, 1);
        check("busy8_fin", busy8, 0);
        check("sum8", sum8, es);
        check("cout8", cout8, ec);
        @(negedge clk);
        check("done8_pulse", done8, 0);
        check("busy8_idle", busy8, 0);
    endtask

    task automatic op1(input logic ta, input logic tb,
                       input logic es, input logic ec);
        @(negedge clk);
        s1 = 1'b1; a1 = ta; b1 = tb; c1 = 1'b0;
        @(negedge clk);
        s1 = 1'b0;
        check("busy1_c1", busy1, 1);
        check("done1_c1", done1, 0);
        @(negedge clk);
        check("done1_c2", done1, 1);
        check("busy1_c2", busy1, 0);
        check("sum1", sum1, es);
        check("cout1", cout1, ec);
        @(negedge clk);
        check("done1_c3", done1, 0);
    endtask

    initial begin
        logic [16:0] exp17;
        int          lat;
        logic        saw_done;

        repeat (2) @(negedge clk);
        check("rst_busy", busy8, 0);
        check("rst_done", done8, 0);
        check("rst_sum", sum8, 0);
        check("rst_cout", cout8, 0);
        rst = 1'b0;

        op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h00);
        op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'h00);

        // start held high through RUN, then back-to-back from FIN
        @(negedge clk);
        s8 = 1'b1; a8 = 8'h3C; b8 = 8'h5A; c8 = 1'b0;
        @(negedge clk);
        a8 = 8'h11;
        for (int k = 1; k <= 8; k++) begin
            check("b2b_busy1", busy8, 1);
            check("b2b_hold", sum8, 8'hFF);
            @(negedge clk);
        end
        check("b2b_done1", done8, 1);
        check("b2b_sum1", sum8, 8'h96);
        check("b2b_cout1", cout8, 0);
        @(negedge clk);
        s8 = 1'b0;
        check("b2b_busy2", busy8, 1);
        check("b2b_done_once", done8, 0);
        check("b2b_hold2", sum8, 8'h96);
        repeat (7) @(negedge clk);
        check("b2b_busy2_end", busy8, 1);
        @(negedge clk);
        check("b2b_done2", done8, 1);
        check("b2b_sum2", sum8, 8'h6B);
        check("b2b_cout2", cout8, 0);
        @(negedge clk);

        // reset in cycle 4 of RUN aborts the operation
        @(negedge clk);
        s8 = 1'b1; a8 = 8'h12; b8 = 8'h34; c8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_c4", busy8, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy8, 0);
        check("abort_done", done8, 0);
        check("abort_sum", sum8, 0);
        check("abort_cout", cout8, 0);
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            saw_done = saw_done | done8 | busy8;
        end
        check("abort_no_done", saw_done, 0);

        op1(1'b0, 1'b0, 1'b0, 1'b0);
        op1(1'b0, 1'b1, 1'b1, 1'b0);
        op1(1'b1, 1'b0, 1'b1, 1'b0);
        op1(1'b1, 1'b1, 1'b0, 1'b1);

        // random 16-bit ops; each new start lands in the FIN cycle
        @(negedge clk);
        for (int n = 0; n < 1000; n++) begin
            s16 = 1'b1;
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            c16 = 1'($urandom);
            exp17 = {1'b0, a16} + {1'b0, b16} + {16'd0, c16};
            @(negedge clk);
            s16 = 1'b0;
            lat = 1;
            while (!done16 && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            check("lat16", lat, 17);
            check("res16", {cout16, sum16}, exp17);
        end
        s16 = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
